// File: rtl/elem_sdiv_by_row_seq_pkg.sv
// Shared types and helpers for the serial matrix sequencers.
// Holds the sequencer state encoding and the index-counter width rule.
package elem_sdiv_by_row_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } seq_state_t;

  // Index counters are 1-based, so they must be able to hold n itself.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/elem_sdiv_by_row_seq_if.sv
// Operand/result bundle for the serial element-by-row divider.
// The master side starts operations; the slave side is the sequencer.
interface elem_sdiv_by_row_seq_if #(
  parameter int unsigned ROWS  = 1,
  parameter int unsigned COLS  = 1,
  parameter int unsigned WIDTH = 16
);
  logic                                    start;
  logic                                    abort;
  logic [ROWS-1:0][COLS-1:0][WIDTH-1:0]    a;
  logic [COLS-1:0][WIDTH-1:0]              b;
  logic                                    busy;
  logic                                    done;
  logic [ROWS-1:0][COLS-1:0][WIDTH-1:0]    f;

  modport master (output start, abort, a, b, input busy, done, f);
  modport slave  (input start, abort, a, b, output busy, done, f);
endinterface

// File: rtl/elem_sdiv_by_row_seq_sdiv_pipe.sv
// One shared saturating signed fixed-point divider followed by PIPE stages
// carrying {valid, row, col, quotient}; flush clears every stage.
module elem_sdiv_by_row_seq_sdiv_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned FRAC  = 8,
  parameter int unsigned PIPE  = 1,
  parameter int unsigned RW    = 1,
  parameter int unsigned CW    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [RW-1:0]    in_row,
  input  logic [CW-1:0]    in_col,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             out_valid,
  output logic [RW-1:0]    out_row,
  output logic [CW-1:0]    out_col,
  output logic [WIDTH-1:0] out_q
);
  // One spare bit so that most-negative / -1 cannot wrap before saturation.
  localparam int unsigned DW = WIDTH + FRAC + 1;
  localparam int unsigned SW = 1 + RW + CW + WIDTH;
  localparam logic signed [DW-1:0] QMax = {{(FRAC + 2){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [DW-1:0] QMin = {{(FRAC + 2){1'b1}}, {(WIDTH - 1){1'b0}}};
  localparam logic [WIDTH-1:0] WMax = {1'b0, {(WIDTH - 1){1'b1}}};
  localparam logic [WIDTH-1:0] WMin = {1'b1, {(WIDTH - 1){1'b0}}};

  logic signed [DW-1:0] num, den, quo;
  logic [WIDTH-1:0]     q;
  logic [SW-1:0]        stage0, stage_out;

  assign num = {opa[WIDTH-1], opa, {FRAC{1'b0}}};
  assign den = {{(FRAC + 1){opb[WIDTH-1]}}, opb};

  always_comb begin
    quo = '0;
    if (den != '0) quo = num / den;
  end

  // Divide-by-zero saturates toward the sign of the dividend.
  always_comb begin
    if (opb == '0)       q = opa[WIDTH-1] ? WMin : WMax;
    else if (quo > QMax) q = WMax;
    else if (quo < QMin) q = WMin;
    else                 q = quo[WIDTH-1:0];
  end

  assign stage0 = {in_valid, in_row, in_col, q};

  if (PIPE == 0) begin : g_comb
    logic unused_flush;
    assign unused_flush = flush;
    assign stage_out    = stage0;
  end else begin : g_pipe
    logic [SW-1:0] pipe_q [PIPE];
    always_ff @(posedge clk or posedge rst) begin
      if (rst || flush) begin
        for (int s = 0; s < int'(PIPE); s++) pipe_q[s] <= '0;
      end else begin
        pipe_q[0] <= stage0;
        for (int s = 1; s < int'(PIPE); s++) pipe_q[s] <= pipe_q[s-1];
      end
    end
    assign stage_out = pipe_q[PIPE-1];
  end

  assign {out_valid, out_row, out_col, out_q} = stage_out;

endmodule

// File: rtl/elem_sdiv_by_row_seq.sv
// Serial f[r][c] = a[r][c] / b[c] using one shared divider: latch operands on start,
// issue elements in raster order, write the held result matrix, pulse done.
module elem_sdiv_by_row_seq
  import elem_sdiv_by_row_seq_pkg::*;
#(
  parameter int unsigned ROWS  = 1,
  parameter int unsigned COLS  = 1,
  parameter int unsigned PIPE  = 1,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned FRAC  = 8
) (
  input logic                  clk,
  input logic                  rst,
  elem_sdiv_by_row_seq_if.slave bus
);
  localparam int unsigned RW = idx_w(ROWS);
  localparam int unsigned CW = idx_w(COLS);

  seq_state_t                           state_q;
  logic [RW-1:0]                        row_q;
  logic [CW-1:0]                        col_q;
  logic [ROWS-1:0][COLS-1:0][WIDTH-1:0] opa_q, f_q;
  logic [COLS-1:0][WIDTH-1:0]           opb_q;
  logic                                 busy_q, done_q;

  logic             issue_valid, last_issue, last_out, flush;
  logic [WIDTH-1:0] sel_a, sel_b, out_q;
  logic             out_valid;
  logic [RW-1:0]    out_row;
  logic [CW-1:0]    out_col;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int r = 0; r < int'(ROWS); r++) begin
      for (int c = 0; c < int'(COLS); c++) begin
        if (row_q == RW'(r + 1) && col_q == CW'(c + 1)) sel_a = opa_q[r][c];
      end
    end
    for (int c = 0; c < int'(COLS); c++) begin
      if (col_q == CW'(c + 1)) sel_b = opb_q[c];
    end
  end

  assign issue_valid = (state_q == StRun);
  assign last_issue  = (row_q == RW'(ROWS)) && (col_q == CW'(COLS));
  assign last_out    = out_valid && (out_row == RW'(ROWS)) && (out_col == CW'(COLS));
  assign flush       = bus.abort && busy_q;

  elem_sdiv_by_row_seq_sdiv_pipe #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .PIPE  (PIPE),
    .RW    (RW),
    .CW    (CW)
  ) u_sdiv_pipe (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (issue_valid),
    .in_row    (row_q),
    .in_col    (col_q),
    .opa       (sel_a),
    .opb       (sel_b),
    .out_valid (out_valid),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_q     (out_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      f_q     <= '0;
    end else begin
      done_q <= 1'b0;
      // A result leaving the pipe is written even on the abort edge itself.
      for (int r = 0; r < int'(ROWS); r++) begin
        for (int c = 0; c < int'(COLS); c++) begin
          if (out_valid && out_row == RW'(r + 1) && out_col == CW'(c + 1)) f_q[r][c] <= out_q;
        end
      end
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            opa_q   <= bus.a;
            opb_q   <= bus.b;
            row_q   <= RW'(1);
            col_q   <= CW'(1);
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (bus.abort) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
          end else if (last_issue) begin
            row_q <= '0;
            col_q <= '0;
            if (PIPE == 0) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= StDrain;
            end
          end else if (col_q == CW'(COLS)) begin
            col_q <= CW'(1);
            row_q <= row_q + RW'(1);
          end else begin
            col_q <= col_q + CW'(1);
          end
        end
        StDrain: begin
          if (bus.abort) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (last_out) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.f    = f_q;

endmodule

// File: tb/tb_elem_sdiv_by_row_seq.sv
// Scoreboard bench: stimulus pushes expected results and done cycles, monitors pop on done.
// Covers a 2x3 PIPE=1 instance plus 1x1 instances with PIPE=0 and PIPE=2.
module tb_elem_sdiv_by_row_seq;
  localparam int W = 16;
  localparam int R = 2;
  localparam int C = 3;
  localparam int P = 1;
  localparam int N = R * C;

  typedef logic [R-1:0][C-1:0][W-1:0] mat_t;
  typedef logic [C-1:0][W-1:0]        row_t;
  typedef struct { mat_t f; int cyc; } exp_t;
  typedef struct { logic [W-1:0] f; int cyc; } exp1_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t  q_m[$];
  exp1_t q_0[$];
  exp1_t q_2[$];
  exp_t  em;
  exp1_t e0m, e2m;
  mat_t  f_model = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  elem_sdiv_by_row_seq_if #(.ROWS(R), .COLS(C), .WIDTH(W)) m ();
  elem_sdiv_by_row_seq_if #(.ROWS(1), .COLS(1), .WIDTH(W)) s0 ();
  elem_sdiv_by_row_seq_if #(.ROWS(1), .COLS(1), .WIDTH(W)) s2 ();

  elem_sdiv_by_row_seq #(.ROWS(R), .COLS(C), .PIPE(P), .WIDTH(W), .FRAC(8)) u_dut (
    .clk (clk), .rst (rst), .bus (m));
  elem_sdiv_by_row_seq #(.ROWS(1), .COLS(1), .PIPE(0), .WIDTH(W), .FRAC(8)) u_dut_p0 (
    .clk (clk), .rst (rst), .bus (s0));
  elem_sdiv_by_row_seq #(.ROWS(1), .COLS(1), .PIPE(2), .WIDTH(W), .FRAC(8)) u_dut_p2 (
    .clk (clk), .rst (rst), .bus (s2));

  // Q8.8 reference: exact quotient truncated toward zero, then clamped.
  function automatic logic [W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint qv;
    if (sb == 0) return (sa < 0) ? 16'h8000 : 16'h7fff;
    qv = (sa * 256) / sb;
    if (qv > 32767)  return 16'h7fff;
    if (qv < -32768) return 16'h8000;
    return W'(qv);
  endfunction

  function automatic mat_t rand_mat();
    mat_t x;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) x[r][c] = W'($urandom);
    return x;
  endfunction

  function automatic logic [W-1:0] rand_b();
    return W'($urandom_range(0, 2047)) - 16'd1024;
  endfunction

  function automatic row_t rand_row();
    row_t x;
    for (int c = 0; c < C; c++) x[c] = rand_b();
    return x;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && m.done) begin
      if (q_m.size() == 0) chk("m_spurious_done", 1, 0);
      else begin
        em = q_m.pop_front();
        chk("m_done_cycle", cyc, em.cyc);
        chk("m_f", m.f, em.f);
      end
    end
    if (!rst && s0.done) begin
      if (q_0.size() == 0) chk("p0_spurious_done", 1, 0);
      else begin
        e0m = q_0.pop_front();
        chk("p0_done_cycle", cyc, e0m.cyc);
        chk("p0_f", s0.f, e0m.f);
      end
    end
    if (!rst && s2.done) begin
      if (q_2.size() == 0) chk("p2_spurious_done", 1, 0);
      else begin
        e2m = q_2.pop_front();
        chk("p2_done_cycle", cyc, e2m.cyc);
        chk("p2_f", s2.f, e2m.f);
      end
    end
  end

  // Called just after a rising edge; returns just after the accept edge.
  task automatic start_op(input mat_t a, input row_t b, input bit expect_done);
    exp_t e;
    m.start = 1'b1;
    m.a = a;
    m.b = b;
    if (expect_done) begin
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) e.f[r][c] = ref_div(a[r][c], b[c]);
      f_model = e.f;
      e.cyc = cyc + 1 + N + P;
      q_m.push_back(e);
    end
    @(posedge clk); #1;
    m.start = 1'b0;
    m.a = rand_mat();
    m.b = rand_row();
  endtask

  // Also pulses start mid-operation; it must be ignored.
  task automatic wait_done();
    int k = 0;
    int busy_cnt = 0;
    while (!m.done && k < 50) begin
      if (m.busy) busy_cnt++;
      if (k == 2) begin
        m.start = 1'b1;
        m.a = rand_mat();
        m.b = rand_row();
      end
      if (k == 3) m.start = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    m.start = 1'b0;
    chk("m_done_seen", m.done, 1);
    chk("m_busy_cycles", busy_cnt, N + P);
  endtask

  task automatic small_op(input logic [W-1:0] a, input logic [W-1:0] b);
    exp1_t e;
    s0.start = 1'b1; s0.a = a; s0.b = b;
    s2.start = 1'b1; s2.a = a; s2.b = b;
    e.f = ref_div(a, b);
    e.cyc = cyc + 2;
    q_0.push_back(e);
    e.cyc = cyc + 4;
    q_2.push_back(e);
    @(posedge clk); #1;
    s0.start = 1'b0; s2.start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
  endtask

  logic [W-1:0] ca [7] = '{16'h0100, 16'h7fff, 16'h8000, 16'h8000, 16'hff00, 16'h0000, 16'h1234};
  logic [W-1:0] cb [7] = '{16'h0200, 16'h0001, 16'h0001, 16'hffff, 16'h0000, 16'h0000, 16'h0080};

  initial begin
    mat_t a;
    row_t b;
    m.start = 0;  m.abort = 0;  m.a = '0;  m.b = '0;
    s0.start = 0; s0.abort = 0; s0.a = '0; s0.b = '0;
    s2.start = 0; s2.abort = 0; s2.a = '0; s2.b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_busy", m.busy, 0);
    chk("reset_done", m.done, 0);
    chk("reset_f", m.f, 0);
    chk("reset_p0_f", s0.f, 0);
    chk("reset_p2_busy", s2.busy, 0);

    // Fixed mixed-sign operands.
    a[0][0] = 16'h0380; a[0][1] = 16'hfe00; a[0][2] = 16'h0100;
    a[1][0] = 16'hf800; a[1][1] = 16'h0040; a[1][2] = 16'hfa00;
    b[0] = 16'h0200; b[1] = 16'hff80; b[2] = 16'h0300;
    start_op(a, b, 1);
    wait_done();
    // Back-to-back start in the done cycle.
    start_op(rand_mat(), rand_row(), 1);
    wait_done();
    // Zero divisor in column 2, both dividend signs.
    a = rand_mat();
    a[0][1] = 16'h0123; a[1][1] = 16'hf321;
    b = rand_row();
    b[1] = 16'h0000;
    start_op(a, b, 1);
    wait_done();

    // Abort sampled at E0+3: only elements 0 and 1 get written.
    a = rand_mat();
    b = rand_row();
    start_op(a, b, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    m.abort = 1'b1;
    @(posedge clk); #1;
    m.abort = 1'b0;
    chk("abort_busy", m.busy, 0);
    chk("abort_done", m.done, 0);
    f_model[0][0] = ref_div(a[0][0], b[0]);
    f_model[0][1] = ref_div(a[0][1], b[1]);
    repeat (10) begin @(posedge clk); #1; end
    chk("abort_f", m.f, f_model);

    // Idle abort together with start: start wins.
    m.abort = 1'b1;
    start_op(rand_mat(), rand_row(), 1);
    m.abort = 1'b0;
    wait_done();

    // Asynchronous reset mid-run.
    start_op(rand_mat(), rand_row(), 0);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", m.busy, 0);
    chk("arst_done", m.done, 0);
    chk("arst_f", m.f, 0);
    f_model = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    start_op(rand_mat(), rand_row(), 1);
    wait_done();

    repeat (8) begin
      start_op(rand_mat(), rand_row(), 1);
      wait_done();
    end

    for (int i = 0; i < 7; i++) small_op(ca[i], cb[i]);
    repeat (12) small_op(W'($urandom), rand_b());

    repeat (6) begin @(posedge clk); #1; end
    chk("m_sb_empty", q_m.size(), 0);
    chk("p0_sb_empty", q_0.size(), 0);
    chk("p2_sb_empty", q_2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
